instr_fetch_unit: RTL and testbench

Fetch-side initiator for the combinational 256x32 instruction memory. Holds the program counter and drives the read address. Captures the returned instruction word each cycle into a small in-order buffer, then presents instruction and PC to decode through a valid/ready handshake. Supports PC redirect (branch/jump) with flush, and a halt input that stops new fetches.

---
 rtl/instr_fetch_unit.sv | 66 ++++++
 tb/tb_instr_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/fetch initiator feeding an in-order instruction buffer to decode,
// with redirect-and-flush and a halt that stops new fetches.
module instr_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [ADDR_W-1:0]              imem_addr,
    input  logic [DATA_W-1:0]              imem_data,
    input  logic                           redirect_valid,
    input  logic [ADDR_W-1:0]              redirect_pc,
    input  logic                           halt,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_instr,
    output logic [ADDR_W-1:0]              out_pc,
    output logic [$clog2(BUF_DEPTH):0]     buf_count
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [DATA_W-1:0] buf_instr [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;

    assign imem_addr = fetch_pc;
    assign out_valid = count != '0;
    assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? buf_pc[rd_ptr] : '0;
    assign buf_count = count;
    assign pop       = out_valid & out_ready;
    // a full buffer can still accept the fetch when the head leaves this cycle
    assign push      = ~redirect_valid & ~halt & ((count < CNT_W'(BUF_DEPTH)) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= ADDR_W'(RESET_PC);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            fetch_pc <= push ? fetch_pc + ADDR_W'(1) : fetch_pc;
            wr_ptr   <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: queue-based reference model checked every cycle, plus directed
// literal expectations for reset, streaming, backpressure, redirect, wrap, halt and async reset.
module tb_instr_fetch_unit;
    logic        clk, rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid, halt, out_valid, out_ready;
    logic [7:0]  redirect_pc, out_pc;
    logic [31:0] out_instr;
    logic [1:0]  buf_count;
    logic [31:0] mem [256];
    int checks = 0, errors = 0;

    typedef struct {logic [7:0] pc; logic [31:0] instr;} entry_t;
    entry_t      mq[$];
    logic [7:0]  mpc;
    logic        m_pop, m_push;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .buf_count(buf_count)
    );

    assign imem_data = mem[imem_addr];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered queue of fetched {pc, instr} capped at two entries
    initial begin
        mpc = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mpc = 8'h00;
            end else begin
                m_pop  = (mq.size() != 0) && out_ready;
                m_push = !redirect_valid && !halt && (mq.size() < 2 || m_pop);
                if (redirect_valid) begin
                    mq.delete();
                    mpc = redirect_pc;
                end else begin
                    if (m_pop) void'(mq.pop_front());
                    if (m_push) begin
                        mq.push_back('{pc: mpc, instr: mem[mpc]});
                        mpc = mpc + 8'd1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("m_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("m_count", 32'(buf_count), 32'(mq.size()));
            check("m_addr", 32'(imem_addr), 32'(mpc));
            check("m_pc", 32'(out_pc), mq.size() != 0 ? 32'(mq[0].pc) : 32'h0);
            check("m_instr", out_instr, mq.size() != 0 ? mq[0].instr : 32'h0);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        rst_n = 0; out_ready = 0; halt = 0; redirect_valid = 0; redirect_pc = 8'h00;
        step(); step();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(buf_count), 32'h0);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_instr", out_instr, 32'h0);
        // streaming from reset
        out_ready = 1; rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t1_valid", 32'(out_valid), 32'h1);
            check("t1_pc", 32'(out_pc), 32'(k));
            check("t1_instr", out_instr, 32'hA000_0000 + 32'(k));
        end
        // backpressure saturates at two entries
        rst_n = 0; out_ready = 0;
        step();
        rst_n = 1;
        for (int k = 0; k < 5; k++) step();
        check("t2_count", 32'(buf_count), 32'h2);
        check("t2_addr", 32'(imem_addr), 32'h2);
        check("t2_pc0", 32'(out_pc), 32'h0);
        out_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t2_pc", 32'(out_pc), 32'(k));
        end
        for (int k = 0; k < 4; k++) step();
        check("t3_pre_pc", 32'(out_pc), 32'h7);
        check("t3_pre_count", 32'(buf_count), 32'h2);
        // redirect flushes pc 7/8
        redirect_valid = 1; redirect_pc = 8'h40;
        step();
        redirect_valid = 0;
        check("t3_valid0", 32'(out_valid), 32'h0);
        check("t3_addr", 32'(imem_addr), 32'h40);
        step();
        check("t3_pc40", 32'(out_pc), 32'h40);
        check("t3_instr40", out_instr, 32'hA000_0040);
        step();
        check("t3_pc41", 32'(out_pc), 32'h41);
        // redirect near the top of memory wraps
        redirect_valid = 1; redirect_pc = 8'hFE;
        step();
        redirect_valid = 0;
        check("t4_valid0", 32'(out_valid), 32'h0);
        step(); check("t4_fe", 32'(out_pc), 32'hFE);
        step(); check("t4_ff", 32'(out_pc), 32'hFF);
        check("t4_ff_instr", out_instr, 32'hA000_00FF);
        step(); check("t4_00", 32'(out_pc), 32'h00);
        check("t4_00_instr", out_instr, 32'hA000_0000);
        step(); check("t4_01", 32'(out_pc), 32'h01);
        // halt drains a full buffer, then resumes without skipping
        out_ready = 0;
        step(); step();
        check("t5_full", 32'(buf_count), 32'h2);
        halt = 1; out_ready = 1;
        step(); check("t5_drain1", 32'(out_pc), 32'h2);
        step(); check("t5_empty", 32'(out_valid), 32'h0);
        step();
        check("t5_empty2", 32'(out_valid), 32'h0);
        check("t5_addr", 32'(imem_addr), 32'h3);
        halt = 0;
        step(); check("t5_res3", 32'(out_pc), 32'h3);
        step(); check("t5_res4", 32'(out_pc), 32'h4);
        // asynchronous reset between edges
        #2 rst_n = 0;
        #1;
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_count", 32'(buf_count), 32'h0);
        check("t6_instr", out_instr, 32'h0);
        check("t6_addr", 32'(imem_addr), 32'h0);
        step();
        rst_n = 1;
        step(); check("t6_pc0", 32'(out_pc), 32'h0);
        step(); check("t6_pc1", 32'(out_pc), 32'h1);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
